// File: rtl/sinegen_pkg.sv
// sinegen_pkg: shared widths, button indices and select type for the sine generator demo
package sinegen_pkg;
  localparam int SEL_W    = 2;
  localparam int N_BTN    = 4;
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_HOME = 2;
  localparam int BTN_LOCK = 3;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/sinegen_btn_ctrl_if.sv
// sinegen_btn_ctrl_if: raw buttons in, debounced/delayed/edge debug taps and selector out
interface sinegen_btn_ctrl_if;
  import sinegen_pkg::*;
  logic [N_BTN-1:0] GPIO_BUTTONS;
  logic [N_BTN-1:0] GPIO_BUTTONS_db;
  logic [N_BTN-1:0] GPIO_BUTTONS_dly;
  logic [N_BTN-1:0] GPIO_BUTTONS_re;
  sel_t             sineSel;
  logic             sel_changed;
  modport master (
    output GPIO_BUTTONS,
    input  GPIO_BUTTONS_db, GPIO_BUTTONS_dly, GPIO_BUTTONS_re, sineSel, sel_changed
  );
  modport slave (
    input  GPIO_BUTTONS,
    output GPIO_BUTTONS_db, GPIO_BUTTONS_dly, GPIO_BUTTONS_re, sineSel, sel_changed
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus counter debounce for one push-button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic db_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          diff, done;
  assign diff = sync_q[1] != db_q;
  assign done = cnt_q == CNT_MAX;
  // any sample agreeing with the accepted level restarts the qualification count
  always_comb begin
    cnt_d = (!diff || done) ? '0 : cnt_q + CW'(1);
    db_d  = (diff && done) ? sync_q[1] : db_q;
  end
  // synchroniser, counter and accepted level all clear on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end
  assign db_o = db_q;
endmodule

// File: rtl/sinegen_btn_ctrl.sv
// sinegen_btn_ctrl: debounced buttons drive the sine frequency selector; SINEGEN_SEL_LOCK_EN adds a lock toggle on button 3
module sinegen_btn_ctrl
  import sinegen_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 1250000,
  parameter sel_t RESET_SEL       = 2'd0
) (
  input logic               clk,
  input logic               reset,
  sinegen_btn_ctrl_if.slave bus
);
  logic [N_BTN-1:0] db, dly_q, re;
  sel_t             sel_q, sel_d;
  logic             chg_q, en;
  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .btn_i (bus.GPIO_BUTTONS[i]),
      .db_o  (db[i])
    );
  end
  assign re = db & ~dly_q;
`ifdef SINEGEN_SEL_LOCK_EN
  logic lock_q;
  assign en = ~lock_q;
`else
  assign en = 1'b1;
`endif
  // home beats up beats down; a locked selector ignores all three
  always_comb begin
    sel_d = !en            ? sel_q :
            re[BTN_HOME]   ? RESET_SEL :
            re[BTN_UP]     ? sel_q + SEL_W'(1) :
            re[BTN_DOWN]   ? sel_q - SEL_W'(1) : sel_q;
  end
  // edge delay, selector and change flag; lock toggles after this cycle's edges are judged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly_q  <= '0;
      sel_q  <= RESET_SEL;
      chg_q  <= 1'b0;
`ifdef SINEGEN_SEL_LOCK_EN
      lock_q <= 1'b0;
`endif
    end else begin
      dly_q  <= db;
      sel_q  <= sel_d;
      chg_q  <= sel_d != sel_q;
`ifdef SINEGEN_SEL_LOCK_EN
      lock_q <= lock_q ^ re[BTN_LOCK];
`endif
    end
  end
  assign bus.GPIO_BUTTONS_db  = db;
  assign bus.GPIO_BUTTONS_dly = dly_q;
  assign bus.GPIO_BUTTONS_re  = re;
  assign bus.sineSel          = sel_q;
  assign bus.sel_changed      = chg_q;
endmodule

// File: tb/tb_sinegen_btn_ctrl.sv
// tb_sinegen_btn_ctrl: directed button presses with a queued scoreboard of edge and selector results
module tb_sinegen_btn_ctrl;
  typedef struct packed {
    logic [3:0] re;
    logic [1:0] sel;
    logic       chg;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t cur;
  bit   pending = 0;
  sinegen_btn_ctrl_if bus();
  sinegen_btn_ctrl #(.DEBOUNCE_CYCLES(4), .RESET_SEL(2'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic [3:0] b, input logic [1:0] sel, input logic chg);
    q.push_back({b, sel, chg});
    bus.GPIO_BUTTONS = b;
    cyc(10);
    bus.GPIO_BUTTONS = '0;
    cyc(10);
  endtask
  task automatic chk_all_zero(input string name);
    chk({name, "_db"}, 8'(bus.GPIO_BUTTONS_db), 8'h0);
    chk({name, "_dly"}, 8'(bus.GPIO_BUTTONS_dly), 8'h0);
    chk({name, "_re"}, 8'(bus.GPIO_BUTTONS_re), 8'h0);
    chk({name, "_sel"}, 8'(bus.sineSel), 8'h0);
    chk({name, "_chg"}, 8'(bus.sel_changed), 8'h0);
  endtask
  initial forever begin
    @(negedge clk);
    if (!reset) pending = 0;
    else begin
      if (pending) begin
        chk("sineSel", 8'(bus.sineSel), 8'(cur.sel));
        chk("sel_changed", 8'(bus.sel_changed), 8'(cur.chg));
        pending = 0;
      end else chk("idle_sel_changed", 8'(bus.sel_changed), 8'h0);
      if (bus.GPIO_BUTTONS_re != 4'h0) begin
        if (q.size() == 0) chk("unexpected_re", 8'(bus.GPIO_BUTTONS_re), 8'h0);
        else begin
          cur = q.pop_front();
          chk("re", 8'(bus.GPIO_BUTTONS_re), 8'(cur.re));
          pending = 1;
        end
      end
    end
  end
  initial begin
    bus.GPIO_BUTTONS = '0;
    #1;
    chk_all_zero("reset");
    cyc(2);
    reset = 1'b1;
    q.push_back({4'b0001, 2'd1, 1'b1});
    bus.GPIO_BUTTONS = 4'b0001;
    cyc(5);
    chk("clean_db_early", 8'(bus.GPIO_BUTTONS_db[0]), 8'h0);
    cyc(1);
    chk("clean_db_rise", 8'(bus.GPIO_BUTTONS_db[0]), 8'h1);
    cyc(4);
    bus.GPIO_BUTTONS = '0;
    cyc(5);
    chk("release_db_early", 8'(bus.GPIO_BUTTONS_db[0]), 8'h1);
    cyc(1);
    chk("release_db_fall", 8'(bus.GPIO_BUTTONS_db[0]), 8'h0);
    cyc(6);
    q.push_back({4'b0001, 2'd2, 1'b1});
    bus.GPIO_BUTTONS = 4'b0001;
    cyc(3);
    bus.GPIO_BUTTONS = '0;
    cyc(1);
    bus.GPIO_BUTTONS = 4'b0001;
    cyc(5);
    chk("bounce_db_early", 8'(bus.GPIO_BUTTONS_db[0]), 8'h0);
    cyc(1);
    chk("bounce_db_rise", 8'(bus.GPIO_BUTTONS_db[0]), 8'h1);
    cyc(4);
    bus.GPIO_BUTTONS = '0;
    cyc(12);
    press(4'b0100, 2'd0, 1'b1);
    press(4'b0001, 2'd1, 1'b1);
    press(4'b0001, 2'd2, 1'b1);
    press(4'b0001, 2'd3, 1'b1);
    press(4'b0001, 2'd0, 1'b1);
    press(4'b0010, 2'd3, 1'b1);
    press(4'b0101, 2'd0, 1'b1);
    press(4'b0100, 2'd0, 1'b0);
    press(4'b0001, 2'd1, 1'b1);
    press(4'b0001, 2'd2, 1'b1);
    press(4'b0011, 2'd3, 1'b1);
    press(4'b0001, 2'd0, 1'b1);
    press(4'b0001, 2'd1, 1'b1);
    press(4'b0001, 2'd2, 1'b1);
    bus.GPIO_BUTTONS = 4'b0001;
    cyc(3);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    cyc(2);
    q.push_back({4'b0001, 2'd1, 1'b1});
    reset = 1'b1;
    cyc(5);
    chk("requal_db_early", 8'(bus.GPIO_BUTTONS_db[0]), 8'h0);
    cyc(1);
    chk("requal_db_rise", 8'(bus.GPIO_BUTTONS_db[0]), 8'h1);
    cyc(4);
    bus.GPIO_BUTTONS = '0;
    cyc(12);
`ifdef SINEGEN_SEL_LOCK_EN
    press(4'b1000, 2'd1, 1'b0);
    press(4'b0001, 2'd1, 1'b0);
    press(4'b0001, 2'd1, 1'b0);
    press(4'b1000, 2'd1, 1'b0);
    press(4'b0001, 2'd2, 1'b1);
`else
    press(4'b1000, 2'd1, 1'b0);
    press(4'b0001, 2'd2, 1'b1);
`endif
    cyc(4);
    chk("queue_drained", 8'(q.size()), 8'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sinegen_btn_ctrl.md
Name: sinegen_btn_ctrl

Overview:
- Upstream control stage for the sine generator demo.
- Synchronises and debounces the four GPIO push-buttons, then registers a one-cycle-delayed copy and derives rising-edge pulses.
- Maintains the 2-bit frequency selector that drives the sine generator's select input.
- Exposes the debounced, delayed and edge signals so the ILA can probe them.

Parameters:
- DEBOUNCE_CYCLES, 1250000, clock cycles a synchronised input must differ from the debounced state before it is accepted (10 ms at 125 MHz); minimum 2.
- RESET_SEL, 2'd0, sineSel value loaded at reset and by the "home" button.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- GPIO_BUTTONS  input  4  raw push-buttons, asynchronous to clk; [0]=up, [1]=down, [2]=home, [3]=lock
- GPIO_BUTTONS_db  output  4  debounced button levels
- GPIO_BUTTONS_dly  output  4  GPIO_BUTTONS_db delayed by one clk
- GPIO_BUTTONS_re  output  4  rising-edge pulses, GPIO_BUTTONS_db & ~GPIO_BUTTONS_dly, one cycle wide
- sineSel  output  2  frequency selector to the sine generator
- sel_changed  output  1  one-cycle pulse in the cycle sineSel takes a new value

Behaviour:
- Reset, while reset=0, asynchronous:
  - sync flops, debounce counters, GPIO_BUTTONS_db and GPIO_BUTTONS_dly go to 0.
  - GPIO_BUTTONS_re = 0, sineSel = RESET_SEL, sel_changed = 0, lock = 0.
  - Deassertion is taken synchronously; the first active edge follows reset going high.
- Synchroniser: 2-FF per bit, reset to 0.
- Debounce, per bit; counter width $clog2(DEBOUNCE_CYCLES):
  - If sync == db: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: db <= sync and counter <= 0.
  - Else: counter <= counter+1.
- Debounce latency and glitch handling:
  - A clean step on GPIO_BUTTONS reaches GPIO_BUTTONS_db exactly 2+DEBOUNCE_CYCLES clocks after the first sampling edge.
  - Any bounce that returns sync to db restarts the count at 0.
  - Release is debounced identically.
- Edge path:
  - GPIO_BUTTONS_dly is registered from GPIO_BUTTONS_db.
  - GPIO_BUTTONS_re is combinational from registered signals, high for exactly one cycle per accepted press.
  - Release generates no pulse.
- Selector update: evaluated on GPIO_BUTTONS_re in the same cycle, with sineSel registered. Priority on simultaneous edges:
  - home (re[2]): sineSel <= RESET_SEL.
  - else up (re[0]): sineSel <= sineSel+1, wrapping 3 to 0.
  - else down (re[1]): sineSel <= sineSel-1, wrapping 0 to 3.
  - Simultaneous up+down with no home: up wins.
- sel_changed is registered alongside sineSel. It is 1 only if the new value differs from the old. Example: home pressed while already at RESET_SEL gives sel_changed=0.
- Latency: from the GPIO_BUTTONS_re cycle to the updated sineSel/sel_changed is 1 clk.
- Reset mid-debounce discards partial counts; a button held through reset must requalify for the full DEBOUNCE_CYCLES after release of reset.
- A held button produces one edge only; there is no auto-repeat.

Optional Feature:
- Macro: SINEGEN_SEL_LOCK_EN.
- Defined:
  - re[3] toggles an internal lock flag (reset 0).
  - While lock=1, up/down/home edges are ignored; sineSel holds and sel_changed stays 0.
  - Edges in the same cycle as the toggle are evaluated against the pre-toggle lock value.
- Undefined:
  - Button 3 is debounced and edge-detected and appears on the debug outputs.
  - It has no effect on sineSel.
  - No lock register is synthesised.

Decomposition:
- Package sinegen_pkg:
  - SEL_W=2 and N_BTN=4.
  - Button index constants BTN_UP=0, BTN_DOWN=1, BTN_HOME=2, BTN_LOCK=3.
  - Shared with the sine generator's select width.
- Sub-module btn_debounce: one bit, containing the 2-FF sync, the counter and the db register, parameterised by DEBOUNCE_CYCLES. Instantiated N_BTN times via generate.
- The edge path, selector and lock stay in the top.

Test Plan (DEBOUNCE_CYCLES=4, RESET_SEL=0):
- Clean press of button 0 held for 10 clks: db[0] rises 6 clks after the first sampling edge; re[0] is high exactly 1 clk; next clk sineSel=1 and sel_changed=1; the release produces no re pulse.
- Bounce on button 0 (high 3 clks, low 1, high 3, then stable): no db change until 4 consecutive differing sync samples; exactly one re[0] pulse and one increment.
- Four up presses from 0: sineSel steps 1, 2, 3, 0. From 0, one down press gives sineSel=3 (wrap).
- Up and down edges in the same cycle at sineSel=2: sineSel=3. Home+up in the same cycle at 3: sineSel=0. Home at 0: sineSel=0 and sel_changed=0.
- reset driven low mid-debounce with button 0 held and sineSel=2: all outputs are 0 immediately (asynchronously), sineSel=0; after reset goes high, db[0] rises 6 clks later and sineSel becomes 1.
- With SINEGEN_SEL_LOCK_EN: press button 3, then press up twice: sineSel is unchanged and sel_changed=0. Press button 3 again, then up: sineSel increments by 1.
